// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: transmit FIFO, programmable baud divider,
// optional even/odd parity and one or two stop bits. The line idles high.
module uart_tx_param #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   input  logic [DIV_WIDTH-1:0]  BAUD_DIV,
   output logic                  TX_OUT,
   output logic                  BUSY,
   output logic                  FIFO_FULL,
   output logic                  FIFO_EMPTY
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int IDX_W = $clog2(DATA_WIDTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [PTR_W:0]        count, count_next;
   logic                  push, pop;

   state_t                state, state_next;
   logic [DIV_WIDTH-1:0]  baud_cnt, baud_cnt_next, div_reg;
   logic [IDX_W-1:0]      bit_idx, bit_idx_next;
   logic [DATA_WIDTH-1:0] data_reg;
   logic                  par_bit, par_en_reg, stop2_reg;
   logic                  bit_end, last_data, last_stop;
   logic                  tx_next, busy_next;

   // Full is taken from the registered count, so a same-cycle pop never frees a slot.
   assign push      = DATA_VALID && !FIFO_FULL;
   assign bit_end   = (baud_cnt == '0);
   assign last_data = (bit_idx == IDX_W'(DATA_WIDTH - 1));
   assign last_stop = (bit_idx == IDX_W'(stop2_reg));
   assign pop       = !FIFO_EMPTY && ((state == IDLE) || (state == STOP && bit_end && last_stop));

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= P_DATA;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         FIFO_FULL  <= 1'b0;
         FIFO_EMPTY <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count      <= count_next;
         FIFO_FULL  <= (count_next == (PTR_W + 1)'(FIFO_DEPTH));
         FIFO_EMPTY <= (count_next == '0);
      end
   end

   // State register; frame settings and the parity bit are captured at pop time.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         data_reg   <= '0;
         par_bit    <= 1'b0;
         par_en_reg <= 1'b0;
         stop2_reg  <= 1'b0;
         div_reg    <= '0;
         TX_OUT     <= 1'b1;
         BUSY       <= 1'b0;
      end else begin
         state    <= state_next;
         baud_cnt <= baud_cnt_next;
         bit_idx  <= bit_idx_next;
         TX_OUT   <= tx_next;
         BUSY     <= busy_next;
         if (pop) begin
            data_reg   <= mem[rd_ptr];
            par_bit    <= (^mem[rd_ptr]) ^ PAR_TYP;
            par_en_reg <= PAR_EN;
            stop2_reg  <= STOP2;
            div_reg    <= BAUD_DIV;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pop) state_next = START;
         START:   if (bit_end) state_next = DATA;
         DATA:    if (bit_end && last_data) state_next = par_en_reg ? PARITY : STOP;
         PARITY:  if (bit_end) state_next = STOP;
         STOP:    if (bit_end && last_stop) state_next = pop ? START : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Bit timing: the divider reloads at every bit boundary, the bit index clears on state change.
   always_comb begin
      baud_cnt_next = baud_cnt;
      bit_idx_next  = bit_idx;
      if (pop) begin
         baud_cnt_next = BAUD_DIV;
         bit_idx_next  = '0;
      end else if (state != IDLE) begin
         if (!bit_end) begin
            baud_cnt_next = baud_cnt - 1'b1;
         end else begin
            baud_cnt_next = div_reg;
            bit_idx_next  = (state_next != state) ? '0 : bit_idx + 1'b1;
         end
      end
   end

   // Line level is computed for the upcoming state so TX_OUT can be driven from a flop.
   always_comb begin
      tx_next   = 1'b1;
      busy_next = (state_next != IDLE);
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = data_reg[bit_idx_next];
         PARITY:  tx_next = par_bit;
         default: tx_next = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: a frame scoreboard filled at write time
// and drained by a line monitor that decodes each frame clock by clock.
module tb_uart_tx_param;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [7:0]  P_DATA = '0;
   logic        DATA_VALID = 1'b0;
   logic        PAR_EN = 1'b0;
   logic        PAR_TYP = 1'b0;
   logic        STOP2 = 1'b0;
   logic [15:0] BAUD_DIV = '0;
   logic        TX_OUT, BUSY, FIFO_FULL, FIFO_EMPTY;

   typedef struct {
      logic [7:0] data;
      bit         pe;
      bit         pt;
      bit         s2;
      int         dv;
   } frame_t;

   frame_t sb[$];
   int     vectors = 0;
   int     miscompares = 0;
   bit     mon_off = 1'b0;

   frame_t mf;
   logic   mbits [16];
   int     mnbits;
   int     idle_wait;
   bit     have;
   logic   line_obs;
   logic   busy_low;
   bit     quiet;

   uart_tx_param #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
      .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .BAUD_DIV(BAUD_DIV),
      .TX_OUT(TX_OUT), .BUSY(BUSY), .FIFO_FULL(FIFO_FULL), .FIFO_EMPTY(FIFO_EMPTY)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One write strobe; the frame expected on the line is queued if the write should land.
   task automatic applyStimulus(input logic [7:0] w, input bit track, input bit pe,
                                input bit pt, input bit s2, input int dv);
      frame_t f;
      P_DATA     = w;
      DATA_VALID = 1'b1;
      if (track) begin
         f.data = w; f.pe = pe; f.pt = pt; f.s2 = s2; f.dv = dv;
         sb.push_back(f);
      end
      @(negedge CLK);
      DATA_VALID = 1'b0;
   endtask

   task automatic wait_drain(input int limit);
      bit done = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge CLK);
         if (sb.size() == 0 && BUSY === 1'b0 && FIFO_EMPTY === 1'b1) begin
            done = 1'b1;
            break;
         end
      end
      checkOutput("drain within budget", done, 1'b1);
      repeat (3) @(negedge CLK);
   endtask

   // Line monitor: expects the start bit within a few clocks of a queued write,
   // or on the very next clock when frames run back to back.
   initial begin : monitor
      have = 1'b0;
      idle_wait = 0;
      forever begin
         if (!have) @(negedge CLK);
         if (mon_off || sb.size() == 0) begin
            have = 1'b0;
            idle_wait = 0;
            continue;
         end
         if (TX_OUT !== 1'b0) begin
            if (have) begin
               checkOutput("no gap between frames", TX_OUT, 1'b0);
               mf = sb.pop_front();
               have = 1'b0;
            end else begin
               idle_wait++;
               if (idle_wait > 4) begin
                  checkOutput("start bit timeout", TX_OUT, 1'b0);
                  mf = sb.pop_front();
                  idle_wait = 0;
               end
            end
            continue;
         end
         have = 1'b0;
         idle_wait = 0;
         mf = sb.pop_front();
         mbits[0] = 1'b0;
         for (int i = 0; i < 8; i++) mbits[1 + i] = mf.data[i];
         mnbits = 9;
         if (mf.pe) begin
            mbits[9] = (^mf.data) ^ mf.pt;
            mnbits = 10;
         end
         mbits[mnbits] = 1'b1;
         mnbits++;
         if (mf.s2) begin
            mbits[mnbits] = 1'b1;
            mnbits++;
         end
         busy_low = 1'b0;
         for (int b = 0; b < mnbits; b++) begin
            line_obs = mbits[b];
            for (int c = 0; c <= mf.dv; c++) begin
               if (b != 0 || c != 0) @(negedge CLK);
               if (TX_OUT !== mbits[b]) line_obs = TX_OUT;
               if (BUSY !== 1'b1) busy_low = 1'b1;
            end
            checkOutput($sformatf("frame %02h bit %0d", mf.data, b), line_obs, mbits[b]);
         end
         checkOutput($sformatf("frame %02h busy held", mf.data), busy_low, 1'b0);
         @(negedge CLK);
         if (!mon_off && sb.size() != 0) begin
            have = 1'b1;
         end else begin
            checkOutput($sformatf("frame %02h line idle after", mf.data), TX_OUT, 1'b1);
            checkOutput($sformatf("frame %02h busy low after", mf.data), BUSY, 1'b0);
         end
      end
   end

   initial begin : stimulus
      bit drained;
      #1 RST = 1'b0;
      repeat (2) @(negedge CLK);
      checkOutput("reset tx_out", TX_OUT, 1'b1);
      checkOutput("reset busy", BUSY, 1'b0);
      checkOutput("reset fifo_empty", FIFO_EMPTY, 1'b1);
      checkOutput("reset fifo_full", FIFO_FULL, 1'b0);
      RST = 1'b1;
      @(negedge CLK);

      $display("[TB] basic frame, even parity, one bit per clock");
      PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; BAUD_DIV = 16'd0;
      applyStimulus(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      checkOutput("latency fifo_empty after write", FIFO_EMPTY, 1'b0);
      checkOutput("latency line still idle", TX_OUT, 1'b1);
      checkOutput("latency busy still low", BUSY, 1'b0);
      @(negedge CLK);
      checkOutput("latency start bit", TX_OUT, 1'b0);
      checkOutput("latency busy high", BUSY, 1'b1);
      wait_drain(100);

      $display("[TB] odd parity, divide by 4, two stop bits");
      PAR_TYP = 1'b1; BAUD_DIV = 16'd3; STOP2 = 1'b1;
      applyStimulus(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 3);
      wait_drain(200);

      $display("[TB] no parity");
      PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b1; BAUD_DIV = 16'd3;
      applyStimulus(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 3);
      wait_drain(200);

      $display("[TB] FIFO fill and drop");
      PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; BAUD_DIV = 16'd15;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(8'(8'h10 + i), (i < 5), 1'b1, 1'b0, 1'b0, 15);
         if (i == 3) checkOutput("fifo_full after 4th write", FIFO_FULL, 1'b0);
         if (i == 4) checkOutput("fifo_full after 5th write", FIFO_FULL, 1'b1);
         if (i == 5) checkOutput("fifo_full after dropped write", FIFO_FULL, 1'b1);
      end
      drained = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge CLK);
         if (sb.size() == 0) begin
            drained = 1'b1;
            break;
         end
      end
      checkOutput("last frame started", drained, 1'b1);
      checkOutput("fifo_empty after last pop", FIFO_EMPTY, 1'b1);
      wait_drain(400);

      $display("[TB] mid-frame configuration change");
      PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; BAUD_DIV = 16'd0;
      applyStimulus(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1);
      @(negedge CLK);
      PAR_TYP = 1'b1; BAUD_DIV = 16'd1;
      wait_drain(200);

      $display("[TB] reset mid-frame");
      mon_off = 1'b1;
      PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; BAUD_DIV = 16'd3;
      applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3);
      applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3);
      applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3);
      repeat (4) @(negedge CLK);
      checkOutput("pre-reset data bit low", TX_OUT, 1'b0);
      checkOutput("pre-reset busy", BUSY, 1'b1);
      checkOutput("pre-reset fifo holds words", FIFO_EMPTY, 1'b0);
      #1 RST = 1'b0;
      #1;
      checkOutput("async reset tx_out", TX_OUT, 1'b1);
      checkOutput("async reset busy", BUSY, 1'b0);
      checkOutput("async reset fifo_empty", FIFO_EMPTY, 1'b1);
      checkOutput("async reset fifo_full", FIFO_FULL, 1'b0);
      @(negedge CLK);
      RST = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (TX_OUT !== 1'b1 || BUSY !== 1'b0) quiet = 1'b0;
      end
      checkOutput("no frame after reset release", quiet, 1'b1);
      mon_off = 1'b0;
      PAR_TYP = 1'b0; BAUD_DIV = 16'd1;
      applyStimulus(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1);
      wait_drain(200);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
